// File: rtl/vta_sim_pkg.sv
// Shared definitions for the TSIM simulation-control block: request codes,
// FSM state encoding and the default request-code width.
package vta_sim_pkg;

  localparam int CODE_BITS_DEFAULT = 8;

  localparam logic [7:0] SIM_RUN    = 8'd0;
  localparam logic [7:0] SIM_WAIT   = 8'd1;
  localparam logic [7:0] SIM_STEP   = 8'd2;
  localparam logic [7:0] SIM_FINISH = 8'd3;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } sim_state_t;

endpackage

// File: rtl/vta_sim_ctrl_if.sv
// Request/status bundle between the DPI-side request sources (master) and
// the simulation-control block (slave).
interface vta_sim_ctrl_if
  import vta_sim_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CODE_BITS = CODE_BITS_DEFAULT,
  parameter int CNT_BITS  = 16
);

  logic [NUM_CH-1:0]           ch_valid;
  logic [NUM_CH*CODE_BITS-1:0] ch_code;
  logic [NUM_CH-1:0]           ch_enable;
  logic [CNT_BITS-1:0]         step_count;
  logic [CNT_BITS-1:0]         timeout_cycles;
  logic                        sim_wait;
  logic                        sim_finish;
  logic [NUM_CH-1:0]           wait_src;
  logic                        timeout;
  logic                        code_err;
  logic [1:0]                  state;

  modport master (
    output ch_valid, ch_code, ch_enable, step_count, timeout_cycles,
    input  sim_wait, sim_finish, wait_src, timeout, code_err, state
  );

  modport slave (
    input  ch_valid, ch_code, ch_enable, step_count, timeout_cycles,
    output sim_wait, sim_finish, wait_src, timeout, code_err, state
  );

endinterface

// File: rtl/vta_sim_prio_enc.sv
// Lowest-index priority encoder: returns the one-hot of the lowest set
// request bit and its binary index (both zero when no bit is set).
module vta_sim_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end else begin
        onehot = onehot;
      end
    end
  end

endmodule

// File: rtl/vta_sim_ctrl.sv
// Simulation-control block: merges per-channel RUN/WAIT/STEP/FINISH requests
// into a registered sim_wait, with counted stepping, a wait watchdog, a
// sticky finish state and a one-cycle request guard after reset release.
module vta_sim_ctrl
  import vta_sim_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CODE_BITS = CODE_BITS_DEFAULT,
  parameter int CNT_BITS  = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  vta_sim_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  sim_state_t          state_q, state_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]    step_ch_q, step_ch_d;
  logic                guard_q, guard_d;
  logic                sim_wait_q, sim_wait_d;
  logic                sim_finish_q, sim_finish_d;
  logic                timeout_q, timeout_d;
  logic                code_err_q, code_err_d;

  logic [NUM_CH-1:0]    wait_live, run_live, step_live;
  logic                 finish_live, bad_code;
  logic [CODE_BITS-1:0] code_i;
  logic [NUM_CH-1:0]    step_oh;
  logic [IDX_W-1:0]     step_idx;
  logic [NUM_CH-1:0]    pending_nxt;
  logic                 wd_expire;

  // Decode live requests per channel; masked, invalid or guarded channels are dropped.
  always_comb begin
    wait_live   = '0;
    run_live    = '0;
    step_live   = '0;
    finish_live = 1'b0;
    bad_code    = 1'b0;
    code_i      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      code_i = bus.ch_code[i*CODE_BITS +: CODE_BITS];
      if (bus.ch_valid[i] && bus.ch_enable[i] && !guard_q) begin
        case (code_i)
          CODE_BITS'(SIM_RUN):    run_live[i]  = 1'b1;
          CODE_BITS'(SIM_WAIT):   wait_live[i] = 1'b1;
          CODE_BITS'(SIM_STEP):   step_live[i] = 1'b1;
          CODE_BITS'(SIM_FINISH): finish_live  = 1'b1;
          default:                bad_code     = 1'b1;
        endcase
      end else begin
        code_i = code_i;
      end
    end
  end

  vta_sim_prio_enc #(.N(NUM_CH), .IDX_W(IDX_W)) u_step_enc (
    .req    (step_live),
    .onehot (step_oh),
    .idx    (step_idx)
  );

  // Next-state, pending mask, step/watchdog counter and output pulse logic.
  always_comb begin
    pending_nxt = (pending_q | wait_live) & ~run_live;
    wd_expire   = (bus.timeout_cycles != '0) &&
                  (cnt_q == bus.timeout_cycles - CNT_BITS'(1));
    state_d     = state_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    step_ch_d   = step_ch_q;
    guard_d     = 1'b0;
    timeout_d   = 1'b0;
    code_err_d  = bad_code;
    if (state_q == ST_DONE) begin
      state_d = ST_DONE;
    end else if (finish_live) begin
      // pending is frozen from here on; DONE ignores everything until reset
      state_d = ST_DONE;
    end else begin
      case (state_q)
        ST_RUN: begin
          pending_d = pending_nxt;
          if (pending_nxt != '0) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else if (step_oh != '0) begin
            state_d   = ST_STEP;
            cnt_d     = bus.step_count;
            step_ch_d = step_idx;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_WAIT: begin
          if (wd_expire) begin
            pending_d = '0;
            state_d   = ST_RUN;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else if (pending_nxt == '0) begin
            pending_d = '0;
            state_d   = ST_RUN;
            cnt_d     = '0;
          end else begin
            pending_d = pending_nxt;
            cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_BITS'(1);
          end
        end
        ST_STEP: begin
          pending_d = pending_nxt;
          if (pending_nxt != '0) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            pending_d[step_ch_q] = 1'b1;
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_BITS'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
    sim_wait_d   = (state_d == ST_WAIT);
    sim_finish_d = (state_d == ST_DONE);
  end

  // State and output registers; the guard flop is held set through reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      pending_q    <= '0;
      cnt_q        <= '0;
      step_ch_q    <= '0;
      guard_q      <= 1'b1;
      sim_wait_q   <= 1'b0;
      sim_finish_q <= 1'b0;
      timeout_q    <= 1'b0;
      code_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      step_ch_q    <= step_ch_d;
      guard_q      <= guard_d;
      sim_wait_q   <= sim_wait_d;
      sim_finish_q <= sim_finish_d;
      timeout_q    <= timeout_d;
      code_err_q   <= code_err_d;
    end
  end

  assign bus.sim_wait   = sim_wait_q;
  assign bus.sim_finish = sim_finish_q;
  assign bus.wait_src   = pending_q;
  assign bus.timeout    = timeout_q;
  assign bus.code_err   = code_err_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_vta_sim_ctrl.sv
// Self-checking bench for vta_sim_ctrl: a behavioural model checked every
// cycle plus hand-computed expectations for the directed scenarios.
module tb_vta_sim_ctrl;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vta_sim_ctrl_if #(.NUM_CH(4), .CODE_BITS(8), .CNT_BITS(16)) bus ();

  vta_sim_ctrl #(.NUM_CH(4), .CODE_BITS(8), .CNT_BITS(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 running, 1 stalled, 2 stepping, 3 finished
  int       m_mode = 0;
  bit [3:0] m_pend = 4'd0;
  int       m_rem = 0;
  int       m_waited = 0;
  int       m_stepch = 0;
  bit       m_guard = 1'b1;
  bit       m_tmo = 1'b0;
  bit       m_cerr = 1'b0;

  task automatic model_edge();
    bit [3:0] waits, runs, steps, newpend;
    bit fin, bad;
    int c;
    waits = 4'd0; runs = 4'd0; steps = 4'd0; fin = 1'b0; bad = 1'b0;
    if (!reset_n) begin
      m_mode = 0; m_pend = 4'd0; m_rem = 0; m_waited = 0;
      m_guard = 1'b1; m_tmo = 1'b0; m_cerr = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.ch_valid[i] && bus.ch_enable[i] && !m_guard) begin
        c = int'(bus.ch_code[i*8 +: 8]);
        if (c == 0) runs[i] = 1'b1;
        else if (c == 1) waits[i] = 1'b1;
        else if (c == 2) steps[i] = 1'b1;
        else if (c == 3) fin = 1'b1;
        else bad = 1'b1;
      end
    end
    m_guard = 1'b0;
    m_cerr = bad;
    m_tmo = 1'b0;
    if (m_mode == 3) return;
    if (fin) begin m_mode = 3; return; end
    newpend = (m_pend | waits) & ~runs;
    if (m_mode == 0) begin
      m_pend = newpend;
      if (newpend != 0) begin m_mode = 1; m_waited = 0; end
      else if (steps != 0) begin
        m_mode = 2; m_rem = int'(bus.step_count);
        m_stepch = 0;
        while (!steps[m_stepch]) m_stepch++;
      end
    end else if (m_mode == 1) begin
      m_waited++;
      if (bus.timeout_cycles != 0 && m_waited == int'(bus.timeout_cycles)) begin
        m_pend = 4'd0; m_mode = 0; m_tmo = 1'b1;
      end else begin
        m_pend = newpend;
        if (newpend == 0) m_mode = 0;
      end
    end else begin
      m_pend = newpend;
      if (newpend != 0) begin m_mode = 1; m_waited = 0; end
      else if (m_rem == 0) begin
        m_pend[m_stepch] = 1'b1; m_mode = 1; m_waited = 0;
      end else m_rem--;
    end
  endtask

  // Advance the model on every edge and compare all outputs just after it.
  always @(posedge clock) begin
    model_edge();
    #1;
    chk("m_sim_wait",   bus.sim_wait,   32'(m_mode == 1));
    chk("m_sim_finish", bus.sim_finish, 32'(m_mode == 3));
    chk("m_wait_src",   bus.wait_src,   32'(m_pend));
    chk("m_timeout",    bus.timeout,    32'(m_tmo));
    chk("m_code_err",   bus.code_err,   32'(m_cerr));
    chk("m_state",      bus.state,      32'(m_mode));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.ch_valid = 4'd0;
    end
  endtask

  task automatic put(input int ch, input logic [7:0] code);
    bus.ch_valid[ch] = 1'b1;
    bus.ch_code[ch*8 +: 8] = code;
  endtask

  int pulses;

  initial begin
    bus.ch_valid = 4'd0;
    bus.ch_code = 32'd0;
    bus.ch_enable = 4'hF;
    bus.step_count = 16'd0;
    bus.timeout_cycles = 16'd0;
    reset_n = 1'b0;
    tick(3);
    chk("rst_state", bus.state, 32'd0);
    chk("rst_wait_src", bus.wait_src, 32'd0);

    // reset guard
    reset_n = 1'b1;
    put(0, 8'd1); tick(1);
    chk("guard_ignored", bus.sim_wait, 32'd0);
    put(0, 8'd1); tick(1);
    chk("guard_after_wait", bus.sim_wait, 32'd1);
    chk("guard_after_src", bus.wait_src, 32'h1);
    put(0, 8'd0); tick(1);
    chk("release_ch0", bus.sim_wait, 32'd0);

    // multi-channel pending
    put(1, 8'd1); tick(1);
    put(2, 8'd1); tick(1);
    chk("multi_src", bus.wait_src, 32'h6);
    put(1, 8'd0); tick(1);
    chk("multi_hold_wait", bus.sim_wait, 32'd1);
    chk("multi_hold_src", bus.wait_src, 32'h4);
    tick(1);
    put(2, 8'd0); tick(1);
    chk("multi_release", bus.sim_wait, 32'd0);

    // step with count 5
    bus.step_count = 16'd5;
    put(0, 8'd2); tick(1);
    for (int i = 0; i < 6; i++) begin
      chk("step5_low", bus.sim_wait, 32'd0);
      chk("step5_state", bus.state, 32'd2);
      tick(1);
    end
    chk("step5_high", bus.sim_wait, 32'd1);
    chk("step5_src", bus.wait_src, 32'h1);
    put(0, 8'd0); tick(1);

    // step with count 0
    bus.step_count = 16'd0;
    put(0, 8'd2); tick(1);
    chk("step0_t1", bus.sim_wait, 32'd0);
    tick(1);
    chk("step0_t2", bus.sim_wait, 32'd1);
    put(0, 8'd0); tick(1);

    // step aborted by a live wait
    bus.step_count = 16'd5;
    put(3, 8'd2); tick(2);
    put(1, 8'd1); tick(1);
    chk("abort_wait", bus.sim_wait, 32'd1);
    chk("abort_src", bus.wait_src, 32'h2);
    put(1, 8'd0); tick(1);

    // watchdog
    bus.timeout_cycles = 16'd10;
    put(3, 8'd1); tick(1);
    for (int i = 0; i < 10; i++) begin
      chk("wd_wait", bus.sim_wait, 32'd1);
      chk("wd_no_pulse", bus.timeout, 32'd0);
      tick(1);
    end
    chk("wd_pulse", bus.timeout, 32'd1);
    chk("wd_drop", bus.sim_wait, 32'd0);
    chk("wd_src", bus.wait_src, 32'd0);
    tick(1);
    chk("wd_one_pulse", bus.timeout, 32'd0);

    // watchdog disabled
    bus.timeout_cycles = 16'd0;
    put(3, 8'd1); tick(1);
    pulses = 0;
    repeat (1000) begin
      tick(1);
      if (bus.timeout) pulses++;
    end
    chk("wd_off_pulses", 32'(pulses), 32'd0);
    chk("wd_off_wait", bus.sim_wait, 32'd1);
    put(3, 8'd0); tick(1);

    // bad code
    put(0, 8'h7F); tick(1);
    chk("bad_code_err", bus.code_err, 32'd1);
    chk("bad_state", bus.state, 32'd0);
    tick(1);
    chk("bad_code_clear", bus.code_err, 32'd0);

    // masked finish
    bus.ch_enable = 4'b1011;
    put(2, 8'd3); tick(1);
    chk("mask_state", bus.state, 32'd0);
    chk("mask_finish", bus.sim_finish, 32'd0);
    bus.ch_enable = 4'hF;

    // reset in the middle of a long step
    bus.step_count = 16'd100;
    put(0, 8'd2); tick(20);
    chk("midstep_state", bus.state, 32'd2);
    reset_n = 1'b0; tick(1);
    chk("midrst_state", bus.state, 32'd0);
    chk("midrst_wait", bus.sim_wait, 32'd0);
    chk("midrst_finish", bus.sim_finish, 32'd0);
    chk("midrst_src", bus.wait_src, 32'd0);
    chk("midrst_tmo", bus.timeout, 32'd0);
    chk("midrst_cerr", bus.code_err, 32'd0);
    reset_n = 1'b1; tick(2);

    // finish beats wait in the same cycle, then sticks
    put(0, 8'd1); put(1, 8'd3); tick(1);
    chk("fin_state", bus.state, 32'd3);
    chk("fin_flag", bus.sim_finish, 32'd1);
    chk("fin_wait", bus.sim_wait, 32'd0);
    put(0, 8'd1); tick(1);
    put(2, 8'd0); tick(1);
    chk("fin_sticky", bus.state, 32'd3);
    chk("fin_sticky_wait", bus.sim_wait, 32'd0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vta_sim_ctrl.md
# vta_sim_ctrl

Parametrised simulation-control block for the TSIM harness: collects wait/step/finish requests from `NUM_CH` DPI-side sources and drives a single registered `sim_wait`. It adds a finish state, counted single-stepping, per-channel masking, pending-request tracking and a wait watchdog. It sits between the DPI call wrappers and the top-level `sim_wait`/`sim_finish` outputs of the test accelerator wrapper.

## Interface
- `NUM_CH`, 4: number of request channels (1..8)
- `CODE_BITS`, 8: width of each request code (byte-wide, matching DPI byte returns)
- `CNT_BITS`, 16: width of step and timeout counters

- `clock`  in  1  sole clock (the simulation clock domain)
- `reset_n`  in  1  synchronous, active-low reset
- `ch_valid`  in  NUM_CH  per-channel code valid, one-cycle qualifier
- `ch_code`  in  NUM_CH*CODE_BITS  per-channel code; channel i at bits [i*CODE_BITS +: CODE_BITS]
- `ch_enable`  in  NUM_CH  channel mask; masked channels are ignored entirely
- `step_count`  in  CNT_BITS  cycles to run after a STEP request, sampled at request
- `timeout_cycles`  in  CNT_BITS  max cycles in WAIT; 0 disables the watchdog
- `sim_wait`  out  1  stall request to the simulator
- `sim_finish`  out  1  sticky end-of-simulation flag
- `wait_src`  out  NUM_CH  pending-wait mask
- `timeout`  out  1  one-cycle pulse on watchdog expiry
- `code_err`  out  1  one-cycle pulse on an unknown code
- `state`  out  2  current FSM state, for debug

## Operation
- Codes: 0 RUN (release), 1 WAIT, 2 STEP, 3 FINISH; values ≥4 are ignored and pulse `code_err`.
- A channel request is live only when both `ch_valid[i]` and `ch_enable[i]` are set.
- Reset guard: the first cycle after `reset_n` rises ignores all requests. This mirrors the one-cycle delayed reset of the existing harness.
- `pending[NUM_CH]` register:
  - live WAIT sets bit i;
  - live RUN clears bit i;
  - a WAIT and a RUN on different channels in the same cycle both take effect.
- FSM states: RUN=0, WAIT=1, STEP=2, DONE=3.
- Transition priority, evaluated every cycle: any live FINISH > pending/new WAIT > STEP > stay.
  - RUN → WAIT when the next value of `pending` is nonzero.
  - RUN → STEP on a live STEP with no WAIT. Loads `cnt = step_count` and records the lowest-index STEP channel in `step_ch`.
  - WAIT → RUN when the next value of `pending` is zero.
  - WAIT → RUN on watchdog expiry. Clears all of `pending` and pulses `timeout`.
  - STEP: `cnt` decrements each cycle. At `cnt == 0`, sets `pending[step_ch]` and moves to WAIT. A live WAIT during STEP aborts the step to WAIT immediately.
  - STEP requests received in WAIT or STEP are ignored.
  - `step_count = 0` means WAIT on the next cycle.
  - Any state → DONE on a live FINISH. DONE is left only by reset.
- Watchdog: `cnt` clears on entry to WAIT and increments while in WAIT. Expiry is `cnt == timeout_cycles - 1` with `timeout_cycles != 0`. The counter saturates rather than wrapping.
- Arithmetic: all counters are unsigned `CNT_BITS` wide; no wrap-around is permitted.

## Timing
- All outputs are registered. A request in cycle t affects `sim_wait`, `state` and `wait_src` in cycle t+1.
- `sim_wait = (state == WAIT)`, `sim_finish = (state == DONE)`.
- STEP with count N: `sim_wait` stays low for N+1 cycles after the request cycle, then rises.
- Reset values while `reset_n = 0`: `sim_wait`, `sim_finish`, `timeout`, `code_err` all 0; `wait_src = 0`; `state = RUN`; counters 0.
- Reset asserted mid-WAIT or mid-STEP: all state is discarded on the next edge, with no residual pulses.

## Structure
- Shared package `vta_sim_pkg`:
  - code constants `SIM_RUN`, `SIM_WAIT`, `SIM_STEP`, `SIM_FINISH`;
  - state enum `sim_state_t`;
  - `CODE_BITS` default.
- Sub-module `vta_sim_prio_enc`: parametrised lowest-index one-hot/index encoder, used for `step_ch`.
- The DPI wrappers stay outside this block so it remains lint-clean and synthesizable.

## Test plan
- Reset guard: hold `reset_n = 0` for 3 cycles, release, drive ch0 WAIT in the first cycle after release → request ignored, `sim_wait = 0`. Repeat one cycle later → `sim_wait = 1` one cycle after.
- Multi-channel pending: ch1 WAIT at t0, ch2 WAIT at t1 → `wait_src = 0b0110`. ch1 RUN → `sim_wait` stays 1. ch2 RUN at t5 → `sim_wait = 0` at t6.
- Step: `step_count = 5`, ch0 STEP at t0 → `sim_wait` low t1..t6, high at t7, `wait_src = 0b0001`. Repeat with `step_count = 0` → `sim_wait` high at t2.
- Watchdog: `timeout_cycles = 10`, ch3 WAIT and never released → `timeout` pulses once after 10 WAIT cycles, `sim_wait` drops, `wait_src = 0`. With `timeout_cycles = 0` → no expiry in 1000 cycles.
- Finish priority and masking:
  - same cycle: ch0 WAIT, ch1 FINISH → `state = DONE`, `sim_finish = 1`, `sim_wait = 0`; later RUN/WAIT codes have no effect;
  - `ch_enable[2] = 0` with ch2 FINISH → no effect.
- Bad code and mid-op reset: ch0 code 0x7F → `code_err` pulses, state unchanged. Then enter STEP with `step_count = 100`, drop `reset_n` at cycle 20 → all outputs at reset values on the next edge.
